// File: rtl/cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : cmd_responder
// Purpose  : UART-style command receiver and response transmitter.
//            RX frames (start, 8 data LSB first, stop) are assembled in pairs
//            into a 16-bit command: the first byte goes to cmd[15:8] and the
//            second to cmd[7:0], after which cmd_rdy is raised. An independent
//            transmitter serialises a single response byte on TX.
// Ports    : clk          - system clock, rising edge
//            rst_n        - asynchronous active-low reset
//            RX           - serial command input (idles high)
//            TX           - serial response output (idles high)
//            cmd[15:0]    - assembled command
//            cmd_rdy      - complete command held on cmd
//            clr_cmd_rdy  - consumer acknowledge, clears cmd_rdy
//            resp[7:0]    - response byte to transmit
//            send_resp    - one-cycle request to transmit resp
//            resp_sent    - one-cycle pulse at the end of the stop bit
// Params   : BAUD_DIV     - clocks per serial bit (>= 4)
//            TIMEOUT_CYC  - inter-byte timeout in clocks (CMD_TIMEOUT_EN only)
// Options  : CMD_TIMEOUT_EN - when defined, a half-assembled command is
//            abandoned after TIMEOUT_CYC clocks without a good byte.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_responder #(
    parameter int BAUD_DIV    = 5208,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(BAUD_DIV - 1);
    // First RX sample lands half a bit after the falling edge was seen.
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]         c_STOP_IDX  = 4'd9;

    if (BAUD_DIV < 4 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("cmd_responder: BAUD_DIV must be >= 4 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [0:0] {RX_IDLE = 1'b0, RX_RECV = 1'b1} rx_state_t;
    typedef enum logic [0:0] {TX_IDLE = 1'b0, TX_XMIT = 1'b1} tx_state_t;
    typedef enum logic [0:0] {ASM_HIGH = 1'b0, ASM_LOW = 1'b1} asm_state_t;

    // ------------------------------------------------------------------------
    // RX synchroniser (resets to the idle level so reset never looks like a
    // start bit)
    // ------------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Receiver FSM. rx_bit_q indexes the frame: 0 = start, 1..8 = data,
    // 9 = stop. rx_cnt_q counts down to the next mid-bit sample.
    // ------------------------------------------------------------------------
    rx_state_t          rx_state_q;
    logic [c_CNT_W-1:0] rx_cnt_q;
    logic [3:0]         rx_bit_q;
    logic [7:0]         rx_shift_q;
    logic               w_rx_tick;
    logic               w_byte_good;

    assign w_rx_tick   = (rx_state_q == RX_RECV) && (rx_cnt_q == '0);
    // A good byte is reported in the same cycle the stop bit is sampled high.
    assign w_byte_good = w_rx_tick && (rx_bit_q == c_STOP_IDX) && rx_sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    if (!rx_sync_q) begin
                        rx_state_q <= RX_RECV;
                        rx_cnt_q   <= c_HALF_LAST;
                        rx_bit_q   <= '0;
                    end
                end
                RX_RECV: begin
                    if (rx_cnt_q != '0) begin
                        rx_cnt_q <= rx_cnt_q - 1'b1;
                    end else begin
                        rx_cnt_q <= c_BAUD_LAST;
                        rx_bit_q <= rx_bit_q + 1'b1;
                        if (rx_bit_q == 4'd0) begin
                            // Line back high at mid start bit: glitch, not a frame.
                            if (rx_sync_q) begin
                                rx_state_q <= RX_IDLE;
                            end
                        end else if (rx_bit_q == c_STOP_IDX) begin
                            rx_state_q <= RX_IDLE;
                        end else begin
                            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
                        end
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional inter-byte timeout: only exists when CMD_TIMEOUT_EN is defined.
    // ------------------------------------------------------------------------
    asm_state_t asm_state_q;

`ifdef CMD_TIMEOUT_EN
    localparam int                c_TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    logic [c_TO_W-1:0] to_cnt_q;
    logic              w_timeout;

    assign w_timeout = (asm_state_q == ASM_LOW) && !w_byte_good && (to_cnt_q == c_TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if ((asm_state_q != ASM_LOW) || w_byte_good || w_timeout) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Byte assembly and command-ready flag. The set/clear on a byte event is
    // written after the acknowledge so that a same-cycle set wins.
    // ------------------------------------------------------------------------
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state_q <= ASM_HIGH;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
        end else begin
            if (clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
            if (w_byte_good) begin
                if (asm_state_q == ASM_HIGH) begin
                    cmd_q[15:8] <= rx_shift_q;
                    asm_state_q <= ASM_LOW;
                    cmd_rdy_q   <= 1'b0;
                end else begin
                    cmd_q[7:0]  <= rx_shift_q;
                    asm_state_q <= ASM_HIGH;
                    cmd_rdy_q   <= 1'b1;
                end
            end
`ifdef CMD_TIMEOUT_EN
            else if (w_timeout) begin
                asm_state_q <= ASM_HIGH;
            end
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Transmitter FSM. tx_bit_q: 0 = start, 1..8 = data, 9 = stop. The start
    // bit is driven directly on acceptance; tx_shift_q holds data + stop.
    // ------------------------------------------------------------------------
    tx_state_t          tx_state_q;
    logic [c_CNT_W-1:0] tx_cnt_q;
    logic [3:0]         tx_bit_q;
    logic [8:0]         tx_shift_q;
    logic               tx_q;
    logic               resp_sent_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_q        <= 1'b1;
            resp_sent_q <= 1'b0;
        end else begin
            resp_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (send_resp) begin
                        tx_state_q <= TX_XMIT;
                        tx_shift_q <= {1'b1, resp};
                        tx_cnt_q   <= c_BAUD_LAST;
                        tx_bit_q   <= '0;
                        tx_q       <= 1'b0;
                    end
                end
                TX_XMIT: begin
                    if (tx_cnt_q != '0) begin
                        tx_cnt_q <= tx_cnt_q - 1'b1;
                    end else if (tx_bit_q == c_STOP_IDX) begin
                        tx_state_q  <= TX_IDLE;
                        resp_sent_q <= 1'b1;
                        tx_q        <= 1'b1;
                    end else begin
                        tx_cnt_q   <= c_BAUD_LAST;
                        tx_bit_q   <= tx_bit_q + 1'b1;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= {1'b1, tx_shift_q[8:1]};
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign TX        = tx_q;
    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_responder
// Purpose  : Directed self-checking bench for cmd_responder with BAUD_DIV=16
//            and TIMEOUT_CYC=1000. Expected values are hand-derived constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_responder;

    localparam int BAUD = 16;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        send_resp;
    logic        resp_sent;

    int checks = 0;
    int errors = 0;

    cmd_responder #(
        .BAUD_DIV    (BAUD),
        .TIMEOUT_CYC (1000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting at the current negedge, then 32 idle clocks.
    task automatic rx_frame(input logic [7:0] b, input logic stop);
        RX = 1'b0;
        repeat (BAUD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BAUD) @(negedge clk);
        end
        RX = stop;
        repeat (BAUD) @(negedge clk);
        RX = 1'b1;
        repeat (32) @(negedge clk);
    endtask

    // Requests a transmit of b and checks every bit mid-period plus the
    // resp_sent pulse 160 clocks after the accepting edge.
    task automatic tx_check(input logic [7:0] b, input bit inject);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        @(negedge clk);
        resp      = b;
        send_resp = 1'b1;
        @(posedge clk);
        #1 send_resp = 1'b0;
        for (int cyc = 1; cyc <= 161; cyc++) begin
            @(posedge clk);
            #1;
            if ((cyc % 16) == 8 && cyc < 160) chk("tx_bit", 16'(TX), 16'(frame[cyc / 16]));
            if (inject && cyc == 50) begin
                resp      = ~b;
                send_resp = 1'b1;
            end
            if (inject && cyc == 51) send_resp = 1'b0;
            if (cyc >= 159) chk("resp_sent", 16'(resp_sent), 16'(cyc == 160));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        RX          = 1'b1;
        clr_cmd_rdy = 1'b0;
        resp        = 8'h00;
        send_resp   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_tx",        16'(TX),        16'h1);
        chk("reset_cmd",       cmd,            16'h0000);
        chk("reset_cmd_rdy",   16'(cmd_rdy),   16'h0);
        chk("reset_resp_sent", 16'(resp_sent), 16'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Command 0x20,0x00 with exact cmd_rdy timing (stop sample at edge 155).
        rx_frame(8'h20, 1'b1);
        chk("high_byte_cmd", cmd, 16'h2000);
        chk("high_byte_rdy", 16'(cmd_rdy), 16'h0);
        fork
            rx_frame(8'h00, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 chk("rdy_before_stop", 16'(cmd_rdy), 16'h0);
                @(posedge clk);
                #1 chk("rdy_after_stop", 16'(cmd_rdy), 16'h1);
            end
        join
        chk("cmd_2000", cmd, 16'h2000);

        // Response 0xA5 with an ignored mid-frame request.
        tx_check(8'hA5, 1'b1);
        chk("tx_idle", 16'(TX), 16'h1);

        // New HIGH byte clears cmd_rdy; set beats a same-cycle acknowledge.
        rx_frame(8'h60, 1'b1);
        chk("high_clears_rdy", 16'(cmd_rdy), 16'h0);
        chk("cmd_6000", cmd, 16'h6000);
        fork
            rx_frame(8'h22, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1 clr_cmd_rdy = 1'b1;
                @(posedge clk);
                #1 clr_cmd_rdy = 1'b0;
                chk("set_wins_rdy", 16'(cmd_rdy), 16'h1);
                chk("set_wins_cmd", cmd, 16'h6022);
            end
        join
        @(negedge clk) clr_cmd_rdy = 1'b1;
        @(negedge clk) clr_cmd_rdy = 1'b0;
        chk("clr_rdy", 16'(cmd_rdy), 16'h0);

        // Framing error byte must be discarded.
        rx_frame(8'h55, 1'b0);
        chk("bad_stop_cmd", cmd, 16'h6022);
        chk("bad_stop_rdy", 16'(cmd_rdy), 16'h0);
        rx_frame(8'h40, 1'b1);
        chk("cmd_4022", cmd, 16'h4022);
        rx_frame(8'h02, 1'b1);
        chk("cmd_4002", cmd, 16'h4002);
        chk("rdy_4002", 16'(cmd_rdy), 16'h1);

        // Reset mid-TX and mid-RX.
        @(negedge clk);
        RX        = 1'b0;
        resp      = 8'h3C;
        send_resp = 1'b1;
        @(negedge clk) send_resp = 1'b0;
        repeat (40) @(negedge clk);
        chk("pre_reset_tx", 16'(TX), 16'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx",      16'(TX),      16'h1);
        chk("midrst_cmd_rdy", 16'(cmd_rdy), 16'h0);
        chk("midrst_cmd",     cmd,          16'h0000);
        @(negedge clk) RX = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (32) @(negedge clk);
        fork
            begin
                rx_frame(8'h47, 1'b1);
                rx_frame(8'hF1, 1'b1);
            end
            tx_check(8'h5A, 1'b0);
        join
        chk("cmd_47f1", cmd, 16'h47F1);
        chk("rdy_47f1", 16'(cmd_rdy), 16'h1);

        // Inter-byte gap longer than the timeout.
        @(negedge clk);
        rx_frame(8'h60, 1'b1);
        repeat (1001) @(negedge clk);
        rx_frame(8'h22, 1'b1);
`ifdef CMD_TIMEOUT_EN
        chk("to_cmd_22f1", cmd, 16'h22F1);
        chk("to_rdy_22f1", 16'(cmd_rdy), 16'h0);
        rx_frame(8'h00, 1'b1);
        chk("to_cmd_2200", cmd, 16'h2200);
        chk("to_rdy_2200", 16'(cmd_rdy), 16'h1);
`else
        chk("noto_cmd_6022", cmd, 16'h6022);
        chk("noto_rdy_6022", 16'(cmd_rdy), 16'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
